// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin, packet-locked arbiter sharing one uart_tx among byte requesters
//
// Purpose:
//   NUM_REQ byte-stream requesters compete for a single uart_tx serializer.
//   A requester wins by round-robin order starting at rr pointer and keeps the
//   UART until it hands over a byte flagged last. Each accepted byte is latched,
//   handed to uart_tx with a one-cycle start pulse, and the arbiter waits for
//   tx_done before offering the next byte slot.
//
// Optional feature (macro UART_ARB_TIMEOUT_EN):
//   When defined, a locked requester that leaves its valid low for
//   TIMEOUT_CYCLES cycles while a byte slot is open loses the lock, and
//   arb_timeout_o pulses for one cycle. When undefined, arb_timeout_o is 0 and
//   a stalled requester holds the UART indefinitely.
//
// Ports:
//   clk            system clock, rising edge
//   rst            asynchronous reset, active high
//   req_valid_i    per-requester byte valid
//   req_data_i     per-requester byte, requester i on [8*i+7:8*i]
//   req_last_i     byte is the last of its packet
//   req_ready_o    byte slot open for the granted requester (one bit at most)
//   uart_start_o   one-cycle start pulse to uart_tx
//   uart_data_o    byte to uart_tx, stable while uart_start_o is high
//   uart_busy_i    uart_tx busy
//   uart_done_i    uart_tx done pulse (end of stop bit)
//   grant_id_o     current / last granted requester
//   grant_active_o packet lock held
//   arb_timeout_o  one-cycle pulse when a locked packet is aborted

module uart_tx_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid_i,
    input  logic [NUM_REQ*8-1:0]       req_data_i,
    input  logic [NUM_REQ-1:0]         req_last_i,
    output logic [NUM_REQ-1:0]         req_ready_o,
    output logic                       uart_start_o,
    output logic [7:0]                 uart_data_o,
    input  logic                       uart_busy_i,
    input  logic                       uart_done_i,
    output logic [$clog2(NUM_REQ)-1:0] grant_id_o,
    output logic                       grant_active_o,
    output logic                       arb_timeout_o
);

    localparam int IDW = $clog2(NUM_REQ);

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_ISSUE     = 2'd1;
    localparam logic [1:0] S_WAIT_BUSY = 2'd2;
    localparam logic [1:0] S_WAIT_DONE = 2'd3;

    logic [1:0]     state_q, state_d;
    logic [IDW-1:0] rr_q, rr_d;
    logic [IDW-1:0] grant_q, grant_d;
    logic           active_q, active_d;
    logic [7:0]     data_q, data_d;
    logic           last_q, last_d;
    logic           start_q, start_d;

    logic [IDW-1:0] pick;
    logic [IDW-1:0] grant_next;
    logic           byte_done;
    logic           release_pkt;

`ifdef UART_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0]  tmo_cnt_q, tmo_cnt_d;
    logic           timeout_q, timeout_d;
`endif

    // First valid requester scanning rr_q, rr_q+1, ... (mod NUM_REQ). The loop
    // runs from the farthest offset down so the nearest offset wins.
    always_comb begin
        logic [IDW-1:0] idx;
        idx  = '0;
        pick = '0;
        for (int off = NUM_REQ - 1; off >= 0; off--) begin
            idx = IDW'((int'(rr_q) + off) % NUM_REQ);
            if (req_valid_i[idx]) begin
                pick = idx;
            end
        end
    end

    assign grant_next = (grant_q == IDW'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;

    always_comb begin
        state_d     = state_q;
        rr_d        = rr_q;
        grant_d     = grant_q;
        active_d    = active_q;
        data_d      = data_q;
        last_d      = last_q;
        start_d     = 1'b0;
        byte_done   = 1'b0;
        release_pkt = 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
        timeout_d   = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (|req_valid_i) begin
                    grant_d  = pick;
                    active_d = 1'b1;
                    state_d  = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (req_valid_i[grant_q]) begin
                    data_d  = req_data_i[{grant_q, 3'b000} +: 8];
                    last_d  = req_last_i[grant_q];
                    start_d = 1'b1;
                    state_d = S_WAIT_BUSY;
                end
`ifdef UART_ARB_TIMEOUT_EN
                else if (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    release_pkt = 1'b1;
                    timeout_d   = 1'b1;
                end
`endif
            end
            S_WAIT_BUSY: begin
                // A done seen before busy still completes the byte.
                if (uart_done_i) begin
                    byte_done = 1'b1;
                end else if (uart_busy_i) begin
                    state_d = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                if (uart_done_i) begin
                    byte_done = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (byte_done) begin
            if (last_q) begin
                release_pkt = 1'b1;
            end else begin
                state_d = S_ISSUE;
            end
        end

        // Timeout abort and a sent last byte release the lock identically.
        if (release_pkt) begin
            active_d = 1'b0;
            rr_d     = grant_next;
            state_d  = S_IDLE;
        end
    end

`ifdef UART_ARB_TIMEOUT_EN
    // Counts open byte slots left unused; anything else clears it.
    always_comb begin
        tmo_cnt_d = '0;
        if (state_q == S_ISSUE && !req_valid_i[grant_q] && !timeout_d) begin
            tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt_q <= '0;
            timeout_q <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign arb_timeout_o = timeout_q;
`else
    // TIMEOUT_CYCLES stays in the parameter list so both builds share one
    // instantiation; it is a non-negative count, so this is constant 0.
    assign arb_timeout_o = (TIMEOUT_CYCLES < 0) ? 1'b1 : 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            rr_q     <= '0;
            grant_q  <= '0;
            active_q <= 1'b0;
            data_q   <= 8'h00;
            last_q   <= 1'b0;
            start_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_q     <= rr_d;
            grant_q  <= grant_d;
            active_q <= active_d;
            data_q   <= data_d;
            last_q   <= last_d;
            start_q  <= start_d;
        end
    end

    always_comb begin
        req_ready_o = '0;
        if (state_q == S_ISSUE) begin
            req_ready_o[grant_q] = 1'b1;
        end
    end

    assign uart_start_o   = start_q;
    assign uart_data_o    = data_q;
    assign grant_id_o     = grant_q;
    assign grant_active_o = active_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - self-checking bench for uart_tx_arbiter with a uart_tx model

module tb_uart_tx_arbiter;

    localparam int N   = 4;
    localparam int CPB = 4;
    localparam int TMO = 20;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [8*N-1:0] req_data;
    logic [N-1:0]   req_last;
    logic [N-1:0]   req_ready;
    logic           uart_start;
    logic [7:0]     uart_data;
    logic           uart_busy;
    logic           uart_done;
    logic [1:0]     grant_id;
    logic           grant_active;
    logic           arb_timeout;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(TMO)) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid_i    (req_valid),
        .req_data_i     (req_data),
        .req_last_i     (req_last),
        .req_ready_o    (req_ready),
        .uart_start_o   (uart_start),
        .uart_data_o    (uart_data),
        .uart_busy_i    (uart_busy),
        .uart_done_i    (uart_done),
        .grant_id_o     (grant_id),
        .grant_active_o (grant_active),
        .arb_timeout_o  (arb_timeout)
    );

    // uart_tx model: 8N1 frame, CPB clocks per bit, plus a mid-bit receiver.
    logic [9:0] frame;
    int         tcnt;
    logic       tx_line;
    logic [7:0] rx_shift;
    logic [7:0] rx_byte;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            uart_busy <= 1'b0;
            uart_done <= 1'b0;
            tx_line   <= 1'b1;
            tcnt      <= 0;
        end else begin
            uart_done <= 1'b0;
            if (!uart_busy) begin
                if (uart_start) begin
                    uart_busy <= 1'b1;
                    frame     <= {1'b1, uart_data, 1'b0};
                    tcnt      <= 0;
                    tx_line   <= 1'b0;
                end
            end else begin
                if (tcnt == 10*CPB - 1) begin
                    uart_busy <= 1'b0;
                    uart_done <= 1'b1;
                    tx_line   <= 1'b1;
                    rx_byte   <= rx_shift;
                end else begin
                    tcnt    <= tcnt + 1;
                    tx_line <= frame[(tcnt + 1) / CPB];
                end
                if (tcnt % CPB == CPB/2 && tcnt / CPB >= 1 && tcnt / CPB <= 8)
                    rx_shift <= {tx_line, rx_shift[7:1]};
            end
        end
    end

    int checks = 0;
    int fails  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int rr_pick(input int rr, input logic [N-1:0] v);
        for (int i = 0; i < N; i++)
            if (v[(rr + i) % N]) return (rr + i) % N;
        return -1;
    endfunction

    function automatic logic [N-1:0] onehot(input int i);
        logic [N-1:0] one;
        one = 1;
        return one << i;
    endfunction

    // Transaction-level model: who owns the UART, round-robin pointer, byte in flight.
    int           m_rr = 0, owner = 0, stall = 0;
    bit           inflight = 0, inflight_last = 0, to_due = 0;
    bit           p_rst = 1, p_active = 0, p_done = 0;
    logic [N-1:0] p_valid = '0, p_ready = '0, p_last = '0;
    logic [8*N-1:0] p_data = '0;
    logic [7:0]   sb_q[$];
    int           grant_log[$];
    logic [7:0]   byte_log[$];
    int           done_count = 0, to_count = 0, cyc_n = 0;
    int           last_done_cyc = 0, last_to_cyc = 0;
    logic [7:0]   last_rx = 8'h00;

    always @(negedge clk) begin
        cyc_n++;
        if (rst) begin
            chk("rst_ready", req_ready, 0);
            chk("rst_start", uart_start, 0);
            chk("rst_data", uart_data, 0);
            chk("rst_grant_id", grant_id, 0);
            chk("rst_active", grant_active, 0);
            chk("rst_timeout", arb_timeout, 0);
            m_rr = 0; owner = 0; stall = 0; inflight = 0; to_due = 0;
            sb_q.delete();
        end else begin
            int  idx;
            bit  exp_start;
            if (req_ready != 0) begin
                chk("ready_onehot", req_ready, onehot(int'(grant_id)));
                chk("ready_needs_lock", grant_active, 1);
            end
            exp_start = !p_rst && ((p_valid & p_ready) != 0);
            chk("start_pulse", uart_start, exp_start);
            if (exp_start) begin
                idx = 0;
                for (int r = 0; r < N; r++) if (p_ready[r]) idx = r;
                chk("start_data", uart_data, p_data[8*idx +: 8]);
                inflight = 1;
                inflight_last = p_last[idx];
                sb_q.push_back(p_data[8*idx +: 8]);
                byte_log.push_back(p_data[8*idx +: 8]);
            end
            chk("timeout_pulse", arb_timeout, to_due);
            if (arb_timeout) begin to_count++; last_to_cyc = cyc_n; end
            if (p_rst) begin
                chk("post_rst_idle", grant_active, 0);
            end else if (!p_active) begin
                if (p_valid != 0) begin
                    owner = rr_pick(m_rr, p_valid);
                    chk("grant_active_rise", grant_active, 1);
                    chk("grant_pick", grant_id, owner);
                    chk("grant_ready", req_ready, onehot(owner));
                    grant_log.push_back(owner);
                    stall = 0;
                end else begin
                    chk("idle_stays", grant_active, 0);
                    chk("idle_grant_hold", grant_id, owner);
                end
            end else if (p_done) begin
                inflight = 0;
                if (inflight_last) begin
                    chk("release_after_last", grant_active, 0);
                    m_rr = (owner + 1) % N;
                end else begin
                    chk("next_byte_slot", req_ready, onehot(owner));
                end
            end else if (to_due) begin
                chk("release_after_timeout", grant_active, 0);
                m_rr = (owner + 1) % N;
            end else begin
                chk("lock_held", grant_active, 1);
                chk("lock_owner", grant_id, owner);
            end
            if (inflight) chk("no_ready_in_flight", req_ready, 0);
            if (uart_done) begin
                chk("done_has_byte", sb_q.size() > 0, 1);
                if (sb_q.size() > 0) begin
                    chk("serial_byte", rx_byte, sb_q[0]);
                    void'(sb_q.pop_front());
                end
                last_rx = rx_byte;
                done_count++;
                last_done_cyc = cyc_n;
            end
            to_due = 0;
`ifdef UART_ARB_TIMEOUT_EN
            if (req_ready != 0) begin
                if (req_valid[owner]) stall = 0;
                else begin
                    stall++;
                    if (stall == TMO) begin to_due = 1; stall = 0; end
                end
            end
`endif
        end
        p_rst = rst; p_active = grant_active; p_done = uart_done;
        p_valid = req_valid; p_ready = req_ready; p_data = req_data; p_last = req_last;
    end

    // Requester streams: entries are {last, byte}; pv is percent chance of valid.
    logic [8:0] sq[N][$];
    int         pv[N];

    task automatic cyc();
        logic [N-1:0] hs;
        for (int r = 0; r < N; r++) begin
            if (sq[r].size() > 0 && $urandom_range(99) < pv[r]) begin
                req_valid[r] = 1'b1;
                req_data[8*r +: 8] = sq[r][0][7:0];
                req_last[r] = sq[r][0][8];
            end else begin
                req_valid[r] = 1'b0;
                req_data[8*r +: 8] = 8'($urandom);
                req_last[r] = 1'($urandom);
            end
        end
        hs = req_valid & req_ready;
        @(posedge clk); #1;
        for (int r = 0; r < N; r++) if (hs[r]) void'(sq[r].pop_front());
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = '0;
        for (int r = 0; r < N; r++) begin sq[r].delete(); pv[r] = 100; end
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        grant_log.delete();
        byte_log.delete();
    endtask

    task automatic run_until_done(input int target, input int bound, input string nm);
        int n = 0;
        while (done_count < target && n < bound) begin cyc(); n++; end
        chk(nm, done_count >= target, 1);
    endtask

    function automatic int glog(input int i);
        return (i < grant_log.size()) ? grant_log[i] : -1;
    endfunction

    function automatic int blog(input int i);
        return (i < byte_log.size()) ? int'(byte_log[i]) : -1;
    endfunction

    initial begin
        int lat, n, base, viol;
        rst = 1'b1; req_valid = '0; req_data = '0; req_last = '0;
        do_reset();

        // Single byte from req0: start latency, serial content, lock release.
        sq[0].push_back({1'b1, 8'hA5});
        lat = 0;
        do begin cyc(); lat++; end while (!uart_start && lat < 10);
        chk("a_start_latency", lat, 2);
        run_until_done(1, 200, "a_wait_done");
        chk("a_active_low", grant_active, 0);
        chk("a_serial_a5", last_rx, 8'hA5);
        sq[0].push_back({1'b1, 8'h01});
        sq[1].push_back({1'b1, 8'h02});
        run_until_done(3, 400, "a_wait_rr");
        chk("a_rr_first_req1", glog(1), 1);
        chk("a_rr_then_req0", glog(2), 0);

        // All four valid from reset: service order 0,1,2,3,0.
        do_reset();
        for (int r = 0; r < N; r++)
            for (int k = 0; k < 2; k++) sq[r].push_back({1'b1, 8'(8'h10*r + k)});
        base = done_count;
        run_until_done(base + 5, 1000, "b_wait");
        for (int i = 0; i < 5; i++) chk($sformatf("b_order_%0d", i), glog(i), i % N);

        // Three-byte packet on req1 locks out a constantly valid req2.
        do_reset();
        sq[1].push_back({1'b0, 8'h11});
        sq[1].push_back({1'b0, 8'h22});
        sq[1].push_back({1'b1, 8'h33});
        for (int k = 0; k < 3; k++) sq[2].push_back({1'b1, 8'(8'h40 + k)});
        base = done_count; viol = 0; n = 0;
        while (done_count < base + 4 && n < 800) begin
            if (req_ready[2] && done_count - base < 3) viol++;
            cyc(); n++;
        end
        chk("c_wait", done_count >= base + 4, 1);
        chk("c_req2_locked_out", viol, 0);
        chk("c_byte0", blog(0), 8'h11);
        chk("c_byte1", blog(1), 8'h22);
        chk("c_byte2", blog(2), 8'h33);
        chk("c_byte3", blog(3), 8'h40);
        chk("c_grant0", glog(0), 1);
        chk("c_grant1", glog(1), 2);

        // req0 stalls mid-packet while req3 waits.
        do_reset();
        sq[0].push_back({1'b0, 8'h5A});
        sq[3].push_back({1'b1, 8'h3C});
`ifdef UART_ARB_TIMEOUT_EN
        n = 0;
        while (to_count == 0 && n < 300) begin cyc(); n++; end
        chk("d_timeout_seen", to_count, 1);
        chk("d_timeout_delay", last_to_cyc - last_done_cyc, TMO + 1);
        n = 0;
        while (grant_log.size() < 2 && n < 50) begin cyc(); n++; end
        chk("d_next_grant_req3", glog(1), 3);
`else
        repeat (1000) cyc();
        chk("d_no_second_grant", grant_log.size(), 1);
        chk("d_still_locked", grant_active, 1);
        chk("d_owner_req0", grant_id, 0);
        chk("d_no_timeout", to_count, 0);
`endif

        // Reset while the arbiter waits for uart_done.
        do_reset();
        sq[2].push_back({1'b0, 8'h77});
        sq[2].push_back({1'b1, 8'h78});
        n = 0;
        while (!uart_busy && n < 60) begin cyc(); n++; end
        chk("e_busy_seen", uart_busy, 1);
        repeat (5) cyc();
        rst = 1'b1;
        req_valid = '0;
        for (int r = 0; r < N; r++) sq[r].delete();
        @(posedge clk); @(posedge clk); #1;
        sq[1].push_back({1'b1, 8'h31});
        sq[3].push_back({1'b1, 8'h33});
        rst = 1'b0;
        grant_log.delete();
        base = done_count;
        run_until_done(base + 2, 400, "e_wait");
        chk("e_first_grant_low", glog(0), 1);
        chk("e_second_grant", glog(1), 3);

        // Randomized traffic; the negedge model checks every cycle.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if (c % 200 == 0)
                for (int r = 0; r < N; r++) pv[r] = $urandom_range(100, 20);
            for (int r = 0; r < N; r++) begin
                if (sq[r].size() < 2) begin
                    int len = $urandom_range(4, 1);
                    for (int k = 0; k < len; k++)
                        sq[r].push_back({(k == len - 1) ? 1'b1 : 1'b0, 8'($urandom)});
                end
            end
            cyc();
        end
        chk("f_traffic_flowed", done_count > base + 20, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
